// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Hazard controller for the 5-stage ARM pipeline. It keeps a private
//   scoreboard of the instructions in EXE/MEM/WB and detects RAW hazards
//   for the instruction in ID. It also freezes the whole pipe while a
//   multi-cycle SRAM access sits in MEM.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   forwarding_en   requested forwarding mode (sampled only when pipe empty)
//   id_*            decoded fields of the instruction currently in ID
//   branch_taken    EXE resolved a taken branch
//   mem_ready       SRAM controller finished the current access
//   hazard_stall    hold PC and IF/ID
//   id_bubble       inject a NOP into ID/EXE
//   flush           clear IF/ID and ID/EXE
//   freeze          hold every pipeline register
//   fwd_en_out      active forwarding mode, drives the forwarding selector
//   stall_count     saturating count of cycles with hazard_stall or freeze
module hazard_sequencer #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forwarding_en,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             id_mem_w_en,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             hazard_stall,
   output logic             id_bubble,
   output logic             flush,
   output logic             freeze,
   output logic             fwd_en_out,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic             mem_r_en;
      logic             mem_w_en;
      logic [REG_W-1:0] dest;
   } slot_t;

   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   slot_t      exe_s, mem_s, wb_s, id_s;
   logic [0:0] state, state_nxt;
   logic       mem_access, wait_start, raw, issue, pipe_empty;
   logic       match_exe, match_mem;

   function automatic logic slot_match(input slot_t s, input logic v,
                                       input logic [REG_W-1:0] s1,
                                       input logic [REG_W-1:0] s2,
                                       input logic two);
      return v & s.valid & s.wb_en & ((s.dest == s1) | (two & (s.dest == s2)));
   endfunction

   always_comb begin
      id_s          = '0;
      id_s.valid    = 1'b1;
      id_s.wb_en    = id_wb_en;
      id_s.mem_r_en = id_mem_r_en;
      id_s.mem_w_en = id_mem_w_en;
      id_s.dest     = id_dest;
   end

   assign match_exe = slot_match(exe_s, id_valid, id_src1, id_src2, id_two_src);
   assign match_mem = slot_match(mem_s, id_valid, id_src1, id_src2, id_two_src);

   // With forwarding only a load in EXE cannot be bypassed in time; without
   // it, any producer still in EXE or MEM blocks. WB writes the register file
   // on the opposite edge, so it never stalls.
   assign raw = fwd_en_out ? (match_exe & exe_s.mem_r_en) : (match_exe | match_mem);

   // Freeze in the very cycle an access reaches MEM, unless the SRAM answers
   // in that same cycle.
   assign mem_access = mem_s.valid & (mem_s.mem_r_en | mem_s.mem_w_en);
   assign wait_start = (state == RUN) & mem_access & ~mem_ready;
   assign freeze     = wait_start | ((state == MEM_WAIT) & ~mem_ready);

   // Priority: freeze > flush > stall. A branch seen during freeze is
   // naturally retried because the EXE slot holds.
   assign flush        = branch_taken & ~freeze;
   assign hazard_stall = raw & ~flush & ~freeze;
   assign id_bubble    = hazard_stall;

   assign issue      = id_valid & ~hazard_stall & ~flush;
   assign pipe_empty = ~exe_s.valid & ~mem_s.valid & ~wb_s.valid;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (wait_start) state_nxt = MEM_WAIT;
         MEM_WAIT: if (mem_ready)  state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_s       <= '0;
         mem_s       <= '0;
         wb_s        <= '0;
         state       <= RUN;
         fwd_en_out  <= 1'b0;
         stall_count <= '0;
      end else begin
         if (!freeze) begin
            wb_s  <= mem_s;
            mem_s <= exe_s;
            exe_s <= issue ? id_s : slot_t'('0);
         end
         state <= state_nxt;
         // Mode changes only take effect with no hazard window open.
         if (pipe_empty) fwd_en_out <= forwarding_en;
         if ((hazard_stall | freeze) && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
   localparam int REG_W = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, forwarding_en, id_valid, id_two_src, id_wb_en;
   logic             id_mem_r_en, id_mem_w_en, branch_taken, mem_ready;
   logic [REG_W-1:0] id_src1, id_src2, id_dest;
   logic             hazard_stall, id_bubble, flush, freeze, fwd_en_out;
   logic [CNT_W-1:0] stall_count;

   always #5 clk = ~clk;

   hazard_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .forwarding_en(forwarding_en),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .hazard_stall(hazard_stall), .id_bubble(id_bubble), .flush(flush),
      .freeze(freeze), .fwd_en_out(fwd_en_out), .stall_count(stall_count)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: in-flight instruction list indexed by distance from ID
   // (0 = one stage ahead, 1 = two ahead, 2 = three ahead).
   bit               m_v[3], m_wb[3], m_ld[3], m_st[3];
   logic [REG_W-1:0] m_d[3];
   int               m_cnt = 0;
   bit               m_fwd = 0;

   initial for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_wb[k] = 0; m_ld[k] = 0; m_st[k] = 0; m_d[k] = '0;
   end

   function automatic bit reads_from(int k);
      return id_valid && m_v[k] && m_wb[k] &&
             (m_d[k] == id_src1 || (id_two_src && m_d[k] == id_src2));
   endfunction
   // The pipe is held exactly while a memory access sits in MEM unanswered.
   function automatic bit m_freeze();
      return m_v[1] && (m_ld[1] || m_st[1]) && !mem_ready;
   endfunction
   function automatic bit m_flush();
      return branch_taken && !m_freeze();
   endfunction
   function automatic bit m_stall();
      bit dep;
      dep = m_fwd ? (reads_from(0) && m_ld[0]) : (reads_from(0) || reads_from(1));
      return dep && !m_flush() && !m_freeze();
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) m_v[k] = 0;
         m_cnt = 0;
         m_fwd = 0;
      end else begin
         bit fz, st, fl, empty;
         fz = m_freeze(); st = m_stall(); fl = m_flush();
         empty = !m_v[0] && !m_v[1] && !m_v[2];
         if (!fz) begin
            for (int k = 2; k > 0; k--) begin
               m_v[k] = m_v[k-1]; m_wb[k] = m_wb[k-1]; m_ld[k] = m_ld[k-1];
               m_st[k] = m_st[k-1]; m_d[k] = m_d[k-1];
            end
            m_v[0] = id_valid && !st && !fl;
            m_wb[0] = id_wb_en; m_ld[0] = id_mem_r_en; m_st[0] = id_mem_w_en; m_d[0] = id_dest;
         end
         if ((st || fz) && m_cnt < 65535) m_cnt++;
         if (empty) m_fwd = forwarding_en;
      end
   end

   always @(negedge clk) begin
      chk("stall",  hazard_stall, m_stall());
      chk("bubble", id_bubble,    m_stall());
      chk("flush",  flush,        m_flush());
      chk("freeze", freeze,       m_freeze());
      chk("fwd",    fwd_en_out,   m_fwd);
      chk("count",  stall_count,  m_cnt);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_id(input bit v, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                         input bit two, input logic [REG_W-1:0] d, input bit wb,
                         input bit ld, input bit st);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
      id_dest = d; id_wb_en = wb; id_mem_r_en = ld; id_mem_w_en = st;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input bit fwd);
      rst = 1; forwarding_en = fwd; branch_taken = 0; mem_ready = 1; idle();
      step(); step();
      rst = 0;
      step();
   endtask

   initial begin
      rst = 1; forwarding_en = 0; branch_taken = 0; mem_ready = 1; idle();

      // load-use with forwarding
      do_reset(1);
      chk("lit_fwd_on", fwd_en_out, 1);
      chk("lit_rst_cnt", stall_count, 0);
      set_id(1, 0, 0, 0, 2, 1, 1, 0);            // LDR r2
      #1 chk("lit_ldr_nostall", hazard_stall, 0);
      step();
      set_id(1, 2, 1, 1, 3, 1, 0, 0);            // ADD r3,r2,r1
      #1 chk("lit_lu_stall", hazard_stall, 1);
      chk("lit_lu_bubble", id_bubble, 1);
      step();
      #1 chk("lit_lu_release", hazard_stall, 0);
      chk("lit_lu_cnt", stall_count, 1);
      step(); idle(); step();

      // no forwarding: two stall cycles
      do_reset(0);
      chk("lit_fwd_off", fwd_en_out, 0);
      set_id(1, 0, 0, 0, 4, 1, 0, 0);            // ADD r4
      step();
      set_id(1, 4, 0, 1, 5, 1, 0, 0);            // SUB r5,r4,r0
      #1 chk("lit_nf_stall_exe", hazard_stall, 1);
      step();
      #1 chk("lit_nf_stall_mem", hazard_stall, 1);
      step();
      #1 chk("lit_nf_release", hazard_stall, 0);
      chk("lit_nf_cnt", stall_count, 2);
      step(); idle(); step();

      // independent and forwarded operands
      do_reset(1);
      set_id(1, 0, 0, 0, 1, 1, 0, 0);            // ADD r1
      step();
      set_id(1, 3, 6, 1, 2, 1, 0, 0);            // ADD r2,r3,r6
      #1 chk("lit_indep", hazard_stall, 0);
      step();
      set_id(1, 1, 1, 1, 2, 1, 0, 0);            // ADD r2,r1,r1
      #1 chk("lit_forwarded", hazard_stall, 0);
      step(); idle();
      #1 chk("lit_indep_cnt", stall_count, 0);
      step();

      // SRAM wait on a store
      do_reset(1);
      set_id(1, 0, 0, 0, 5, 0, 0, 1);            // STR
      step(); idle(); mem_ready = 0;
      #1 chk("lit_str_exe", freeze, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         #1 chk("lit_sram_freeze", freeze, 1);
         step();
      end
      mem_ready = 1;
      #1 chk("lit_sram_ready", freeze, 0);
      chk("lit_sram_cnt", stall_count, 4);
      step();
      #1 chk("lit_sram_cnt_after", stall_count, 4);
      step();

      // branch versus stall, then branch versus freeze
      do_reset(1);
      set_id(1, 0, 0, 0, 2, 1, 1, 0);            // LDR r2
      step();
      set_id(1, 2, 1, 1, 3, 1, 0, 0); branch_taken = 1;
      #1 chk("lit_br_flush", flush, 1);
      chk("lit_br_nostall", hazard_stall, 0);
      step(); branch_taken = 0; idle();
      #1 chk("lit_br_done", flush, 0);
      step();
      set_id(1, 0, 0, 0, 7, 1, 1, 0);            // LDR r7
      step(); idle(); mem_ready = 0;
      step(); branch_taken = 1;
      #1 chk("lit_brfz_freeze", freeze, 1);
      chk("lit_brfz_noflush", flush, 0);
      step();
      #1 chk("lit_brfz_noflush2", flush, 0);
      mem_ready = 1;
      #1 chk("lit_brfz_unfreeze", freeze, 0);
      chk("lit_brfz_flush", flush, 1);
      step(); branch_taken = 0; step();

      // saturation, then reset during MEM_WAIT
      do_reset(1);
      set_id(1, 0, 0, 0, 7, 1, 1, 0);            // LDR r7
      step(); idle(); mem_ready = 0;
      step();
      repeat ((1 << CNT_W) + 3) step();
      chk("lit_sat_cnt", stall_count, 16'hFFFF);
      chk("lit_sat_freeze", freeze, 1);
      rst = 1;
      step();
      #1 chk("lit_rst_freeze", freeze, 0);
      chk("lit_rst_cnt0", stall_count, 0);
      rst = 0; mem_ready = 1;
      step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage ARM core.
- Keeps its own scoreboard of in-flight register writes in the EXE, MEM and WB slots, and detects RAW hazards for the instruction in ID.
- Drives the stall/bubble/flush/freeze controls for IF/ID/EXE/MEM/WB, and provides the forwarding enable consumed by the forwarding mux selector.
- Also sequences multi-cycle SRAM accesses by freezing the pipe until the memory controller reports ready.

Parameters:
- REG_W, 4, register index width.
- CNT_W, 16, width of the saturating stall-statistics counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- forwarding_en  input  1  1 = forwarding path active; 0 = stall on every RAW.
- id_valid  input  1  ID holds a real instruction.
- id_src1  input  REG_W  first source register.
- id_src2  input  REG_W  second source register.
- id_two_src  input  1  id_src2 is actually read.
- id_dest  input  REG_W  destination register.
- id_wb_en  input  1  ID instruction writes a register.
- id_mem_r_en  input  1  ID instruction is a load.
- id_mem_w_en  input  1  ID instruction is a store.
- branch_taken  input  1  EXE resolved a taken branch.
- mem_ready  input  1  SRAM controller finished the current access.
- hazard_stall  output  1  hold PC and IF/ID.
- id_bubble  output  1  inject a NOP into ID/EXE.
- flush  output  1  clear IF/ID and ID/EXE (taken branch).
- freeze  output  1  hold all pipeline registers.
- fwd_en_out  output  1  registered copy of forwarding_en, drives the forwarding selector.
- stall_count  output  CNT_W  number of cycles with hazard_stall or freeze asserted.

Behaviour:
- Reset (rst=1 at posedge clk), all registered outputs 0:
  - every scoreboard slot invalid;
  - state=RUN;
  - stall_count=0, fwd_en_out=0.
- Scoreboard:
  - Three slots, EXE/MEM/WB; each holds {valid, wb_en, mem_r_en, mem_w_en, dest}.
  - Each clock when freeze=0: WB<=MEM, MEM<=EXE.
  - EXE<=ID fields when id_valid & ~hazard_stall & ~flush; otherwise EXE<=invalid (bubble).
  - When freeze=1, all slots hold.
- Match definitions:
  - match(slot) = slot.valid & slot.wb_en & (slot.dest==id_src1 | (id_two_src & slot.dest==id_src2)).
  - id_valid=0 means no match.
- Hazard, combinational from the scoreboard and ID inputs:
  - fwd_en_out=1: hazard_stall = match(EXE) & EXE.mem_r_en (load-use only).
  - fwd_en_out=0: hazard_stall = match(EXE) | match(MEM).
  - The WB slot never causes a stall; the register file writes on the opposite edge.
  - id_bubble = hazard_stall.
- Branch handling:
  - flush = branch_taken & ~freeze.
  - Flush has priority over stall: when flush=1, hazard_stall and id_bubble are forced 0.
- Memory FSM, states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when MEM.valid & (MEM.mem_r_en | MEM.mem_w_en) & ~mem_ready.
  - MEM_WAIT -> RUN on mem_ready=1.
  - freeze = (state==RUN & transition condition) | (state==MEM_WAIT & ~mem_ready). Freeze therefore asserts in the same cycle the access enters MEM.
  - mem_ready=1 in the first MEM cycle means a single-cycle access: no freeze, no state change.
  - While freeze=1: hazard_stall, id_bubble and flush are forced 0, and nothing advances.
  - A pending branch_taken is re-evaluated once freeze drops, because the EXE slot holds.
- fwd_en_out is sampled from forwarding_en only when the pipe is empty (all three slots invalid) or at reset. This prevents a mode change in the middle of a hazard window.
- stall_count:
  - Increments by 1 in every cycle with (hazard_stall | freeze).
  - Saturates at all-ones; no wrap.
- Reset mid-access: rst forces state=RUN and clears the slots regardless of mem_ready. The memory controller is reset by the same rst.
- Latency:
  - Hazard outputs are combinational, zero cycles.
  - The scoreboard updates one cycle after issue.

Test Plan:
- Load-use with forwarding: fwd=1, LDR r2 issued, then ADD r3,r2,r1 in ID -> hazard_stall=1 and id_bubble=1 for exactly 1 cycle, EXE slot invalid next cycle, stall_count=1.
- No forwarding: fwd=0, ADD r4 issued, then SUB r5,r4,r0 -> stall for 2 cycles (EXE then MEM match), released when r4 reaches WB; stall_count=2.
- Independent operands: fwd=1, ADD r1 issued, then ADD r2,r3,r6 -> no stall; forwarded case ADD r1 then ADD r2,r1,r1 -> no stall.
- SRAM wait: STR reaches MEM with mem_ready low for 4 cycles -> freeze=1 for 4 cycles, state MEM_WAIT, slots unchanged; mem_ready=1 -> freeze=0 that cycle, pipe advances next edge.
- Branch vs stall: branch_taken=1 in the same cycle as a load-use match -> flush=1, hazard_stall=0. Repeat with freeze=1 -> flush held 0 until freeze drops.
- Reset and saturation: assert rst during MEM_WAIT -> next cycle state RUN, freeze=0, stall_count=0. Force 2^CNT_W+3 stall cycles -> stall_count stays 0xFFFF.
